// File: rtl/micro_datapath.sv
// Execution datapath for the microcoded sequencer: accumulator/operand ALU,
// carry and condition flags, polled input port and a one-entry output buffer.
module micro_datapath #(
    parameter int P_WIDTH          = 8,
    parameter int P_NUM_D_CTRLBITS = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [P_NUM_D_CTRLBITS-1:0] dp_ctrl,
    input  logic [P_WIDTH-1:0]          din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic [P_WIDTH-1:0]          dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        cres,
    output logic [P_WIDTH-1:0]          acc_o
);

    generate
        if (P_NUM_D_CTRLBITS != 5) begin : g_bad_cfg
            $error("micro_datapath: P_NUM_D_CTRLBITS must be 5");
        end
    endgenerate

    localparam logic [4:0] OP_CLR    = 5'h01;
    localparam logic [4:0] OP_LDB    = 5'h02;
    localparam logic [4:0] OP_ADD    = 5'h03;
    localparam logic [4:0] OP_SUB    = 5'h04;
    localparam logic [4:0] OP_AND    = 5'h05;
    localparam logic [4:0] OP_OR     = 5'h06;
    localparam logic [4:0] OP_XOR    = 5'h07;
    localparam logic [4:0] OP_INC    = 5'h08;
    localparam logic [4:0] OP_DEC    = 5'h09;
    localparam logic [4:0] OP_SHL    = 5'h0A;
    localparam logic [4:0] OP_SHR    = 5'h0B;
    localparam logic [4:0] OP_TRYIN  = 5'h0C;
    localparam logic [4:0] OP_TRYOUT = 5'h0D;
    localparam logic [4:0] OP_TSTZ   = 5'h0E;
    localparam logic [4:0] OP_TSTC   = 5'h0F;
    localparam logic [4:0] OP_SWAP   = 5'h10;

    localparam logic [P_WIDTH-1:0] ONE_W  = {{(P_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P_WIDTH-1:0] ZERO_W = {P_WIDTH{1'b0}};

    logic [P_WIDTH-1:0] acc_q, acc_d;
    logic [P_WIDTH-1:0] b_q, b_d;
    logic [P_WIDTH-1:0] obuf_q, obuf_d;
    logic               c_q, c_d;
    logic               f_q, f_d;
    logic               ov_q, ov_d;
    logic [P_WIDTH:0]   sum_s;
    logic               space_s;

    assign din_ready  = (dp_ctrl == OP_TRYIN);
    assign sum_s      = {1'b0, acc_q} + {1'b0, b_q};
    assign space_s    = ~ov_q | dout_ready;
    assign acc_o      = acc_q;
    assign dout       = obuf_q;
    assign dout_valid = ov_q;
    assign cres       = f_q;

    // Opcode decode: next-state for every datapath register.
    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        c_d    = c_q;
        f_d    = f_q;
        obuf_d = obuf_q;
        // The buffered word drains whenever the consumer takes it; TRYOUT may refill below.
        ov_d   = ov_q & ~dout_ready;
        case (dp_ctrl)
            OP_CLR: acc_d = ZERO_W;
            OP_LDB: b_d   = acc_q;
            OP_ADD: {c_d, acc_d} = sum_s;
            OP_SUB: begin
                acc_d = acc_q - b_q;
                c_d   = (acc_q < b_q);
            end
            OP_AND: acc_d = acc_q & b_q;
            OP_OR:  acc_d = acc_q | b_q;
            OP_XOR: acc_d = acc_q ^ b_q;
            OP_INC: begin
                acc_d = acc_q + ONE_W;
                c_d   = &acc_q;
            end
            OP_DEC: begin
                acc_d = acc_q - ONE_W;
                c_d   = (acc_q == ZERO_W);
            end
            OP_SHL: begin
                acc_d = {acc_q[P_WIDTH-2:0], 1'b0};
                c_d   = acc_q[P_WIDTH-1];
            end
            OP_SHR: begin
                acc_d = {1'b0, acc_q[P_WIDTH-1:1]};
                c_d   = acc_q[0];
            end
            OP_TRYIN: begin
                if (din_valid) begin
                    acc_d = din;
                    f_d   = 1'b1;
                end else begin
                    f_d   = 1'b0;
                end
            end
            OP_TRYOUT: begin
                if (space_s) begin
                    obuf_d = acc_q;
                    ov_d   = 1'b1;
                    f_d    = 1'b1;
                end else begin
                    f_d    = 1'b0;
                end
            end
            OP_TSTZ: f_d = (acc_q == ZERO_W);
            OP_TSTC: f_d = c_q;
            OP_SWAP: begin
                acc_d = b_q;
                b_d   = acc_q;
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= ZERO_W;
            b_q    <= ZERO_W;
            obuf_q <= ZERO_W;
            c_q    <= 1'b0;
            f_q    <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            obuf_q <= obuf_d;
            c_q    <= c_d;
            f_q    <= f_d;
            ov_q   <= ov_d;
        end
    end

endmodule

// File: doc/micro_datapath.md
# micro_datapath

Execution datapath driven by the microcoded sequencer. Each cycle it decodes the 5-bit `dp_ctrl` word produced by the sequencer and updates an accumulator, an operand register and the flags. It exchanges words with the outside world through a polled input port and a one-entry output buffer. It returns the 1-bit condition `cres` that the sequencer uses for conditional jumps.

## Interface
- `P_WIDTH`, 8: data word width (≥2).
- `P_NUM_D_CTRLBITS`, 5: control word width. Fixed at 5; any other value is a configuration error.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `dp_ctrl` in 5: microinstruction opcode, valid for the whole cycle.
- `din` in P_WIDTH: input data word.
- `din_valid` in 1: input word available.
- `din_ready` out 1: input word consumed this cycle.
- `dout` out P_WIDTH: output buffer contents.
- `dout_valid` out 1: output buffer full.
- `dout_ready` in 1: consumer takes `dout` this cycle.
- `cres` out 1: condition flag to the sequencer, registered.
- `acc_o` out P_WIDTH: accumulator, for debug and observation.

## Operation
State registers:
- `acc`, `b`: P_WIDTH each.
- `c`: carry.
- `f`: condition flag; `cres` = `f`.
- `obuf`: drives `dout`.
- `ov`: drives `dout_valid`.

Opcodes (hex). All arithmetic is modulo 2^P_WIDTH. Registers not listed for an opcode hold their value.
- 00 NOP.
- 01 CLR: acc←0.
- 02 LDB: b←acc.
- 03 ADD: {c,acc}←acc+b.
- 04 SUB: acc←acc−b; c←(acc<b) unsigned borrow.
- 05 AND, 06 OR, 07 XOR: acc←acc op b; c unchanged.
- 08 INC: acc←acc+1; c←(acc was all-ones).
- 09 DEC: acc←acc−1; c←(acc was 0).
- 0A SHL: acc←{acc[W-2:0],0}; c←acc[W-1].
- 0B SHR: acc←{0,acc[W-1:1]}; c←acc[0].
- 0C TRYIN: `din_ready`=1 combinationally this cycle.
  - If `din_valid`: acc←din, f←1.
  - Else: f←0, acc unchanged.
- 0D TRYOUT: space = !ov | dout_ready.
  - If space: obuf←acc, ov←1, f←1.
  - Else: f←0.
- 0E TSTZ: f←(acc==0).
- 0F TSTC: f←c.
- 10 SWAP: acc↔b.
- 11–1F: NOP (must not change any state).
- `f` changes only on TRYIN, TRYOUT, TSTZ and TSTC.

Output buffer:
- ov clears when ov & dout_ready and no TRYOUT loads in the same cycle.
- TRYOUT with ov=1 and dout_ready=1 hands the old word off and loads the new one in the same edge; ov stays 1.
- obuf never changes while ov=1 unless dout_ready=1.

Input port:
- `din_ready` is high only during TRYIN, independent of `din_valid`.
- A transfer happens only when both `din_valid` and `din_ready` are high.

## Timing
- Single-cycle execution: the opcode presented in cycle N updates state at the edge ending cycle N.
- `cres` is registered. It reflects `f` as written by the last flag-writing instruction. The sequencer therefore branches, at the end of instruction N+1, on a flag produced by instruction N. Microcode places the jump one instruction after the test; a polling loop is TRYIN followed by a jump-if-0/1 word.
- `acc_o`, `dout`, `dout_valid` and `cres` are direct register outputs. `din_ready` is a combinational decode of `dp_ctrl` only.
- Reset values: acc=0, b=0, c=0, f=0 (`cres`=0), obuf=0 (`dout`=0), ov=0 (`dout_valid`=0). `din_ready` follows `dp_ctrl` combinationally, including during reset.
- Reset mid-operation: all registers clear immediately (asynchronously). A word being offered on `dout` is dropped. A TRYIN in the reset cycle has no effect on `acc`.
- No state updates while `rst` is high.

## Test plan
- Reset: assert rst mid-run with acc=0x5A and ov=1 → acc_o=0, dout_valid=0, cres=0 immediately, before the next edge.
- Arithmetic, with W=8:
  - acc=0xF0, b=0x20, ADD → acc=0x10, c=1; then TSTC → cres=1 on the next cycle.
  - SUB with acc=0x05, b=0x07 → acc=0xFE, c=1.
- Input polling:
  - TRYIN with din_valid=0 → din_ready=1, acc unchanged, cres=0.
  - Next TRYIN with din=0x3C, din_valid=1 → acc=0x3C, cres=1.
- Output full/drain:
  - acc=0x11, TRYOUT → dout=0x11, dout_valid=1, cres=1.
  - acc=0x22, TRYOUT with dout_ready=0 → dout stays 0x11, cres=0.
  - Repeat TRYOUT with dout_ready=1 → dout=0x22, dout_valid=1, cres=1.
- Drain without reload: ov=1, NOP with dout_ready=1 → dout_valid=0 the next cycle, dout holds its last value.
- Shifts, swap, undefined opcodes:
  - acc=0x81, SHL → acc=0x02, c=1.
  - SWAP with acc=0x02, b=0x99 → acc=0x99, b=0x02.
  - Opcodes 0x11–0x1F applied for 15 cycles → no change to any state.
